lsu_axil: RTL

Parametrised load/store unit between the core's execute/writeback stage and an AXI4-Lite data port. Accepts one memory request at a time from the core over a valid/ready handshake. Handles:
- sub-word byte-lane placement and extraction by address offset;
- sign or zero extension of loads;
- issuing AW and W channels concurrently;
- misalignment checks;
- bus error responses;
- a watchdog timeout.
Each completed request returns a single-cycle response pulse.

---
 rtl/lsu_pkg.sv | 68 ++++++
 rtl/lsu_lane_align.sv | 76 +++++++
 rtl/lsu_axil.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: access-size codes,
//            response codes, FSM state encoding, AXI response values and the
//            alignment / bus-error helpers.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size codes (req_size)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Completion codes (rsp_err)
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // AXI xRESP encodings
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    BRESP = 3'd4,
    DONE  = 3'd5
  } lsu_state_e;

  // An access is misaligned when any address bit below its natural size is
  // set. A double access on a 32-bit bus cannot be served at all, so it is
  // reported the same way.
  function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                         input logic [1:0] size,
                                         input logic       dbl_ok);
    logic [2:0] mask;
    case (size)
      SZ_B:    mask = 3'b000;
      SZ_H:    mask = 3'b001;
      SZ_W:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return (|(addr_lo & mask)) || ((size == SZ_D) && !dbl_ok);
  endfunction

  // AXI4-Lite carries no exclusive accesses, so EXOKAY can only come from a
  // misbehaving slave and is treated like any other non-OKAY response.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      AXI_OKAY:   err = 1'b0;
      AXI_EXOKAY: err = 1'b1;
      AXI_SLVERR: err = 1'b1;
      AXI_DECERR: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational byte-lane steering for a DATA_W-bit data bus.
//            Store side: shifts right-aligned data onto its lanes and builds
//            the byte strobes. Load side: extracts the addressed bytes to
//            bit 0 and sign/zero-extends them.
// Ports    : offset_i     - byte offset within the bus word
//            size_i       - access size code (SZ_*)
//            sext_i       - sign-extend the load result
//            store_data_i - right-aligned store data
//            load_data_i  - raw bus read data
//            store_data_o - lane-placed store data
//            strb_o       - byte strobes
//            load_data_o  - extracted, extended load data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [DATA_W-1:0] store_data_o,
  output logic [STRB_W-1:0] strb_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [STRB_W-1:0] lane_mask;
  logic [DATA_W-1:0] load_shifted;
  logic              sign_bit;
  int                keep_bits;

  assign store_data_o = store_data_i << {offset_i, 3'b000};
  assign strb_o       = lane_mask << offset_i;
  assign load_shifted = load_data_i >> {offset_i, 3'b000};

  always_comb begin
    lane_mask   = '1;
    keep_bits   = DATA_W;
    sign_bit    = 1'b0;
    load_data_o = '0;
    case (size_i)
      SZ_B: begin
        lane_mask = STRB_W'(1);
        keep_bits = 8;
        sign_bit  = load_shifted[7];
      end
      SZ_H: begin
        lane_mask = STRB_W'(3);
        keep_bits = 16;
        sign_bit  = load_shifted[15];
      end
      SZ_W: begin
        // On a 32-bit bus keep_bits covers the whole word, so no extension.
        lane_mask = STRB_W'(15);
        keep_bits = 32;
        sign_bit  = load_shifted[31];
      end
      default: begin
        // Double: full bus width, nothing to extend.
      end
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      load_data_o[i] = (i < keep_bits) ? load_shifted[i] : (sext_i & sign_bit);
    end
  end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/lsu_axil.sv
`default_nettype none
// ============================================================================
// Module   : lsu_axil
// Purpose  : Single-outstanding load/store unit bridging the core to an
//            AXI4-Lite data port. Handles lane placement, load extension,
//            misalignment, bus errors and a transaction watchdog; every
//            request ends in a one-cycle rsp_valid pulse.
// Ports    : clk/rst              - clock, async active-low reset
//            req_*                - core request (valid/ready)
//            rsp_*                - completion pulse, load data, error code
//            ar*/r*               - AXI4-Lite read channels
//            aw*/w*/b*            - AXI4-Lite write channels
// Revision : 1.0 - initial release
// ============================================================================
module lsu_axil
  import lsu_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 1024,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int OFF_W = $clog2(STRB_W);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic              busy;
  logic              timeout;
  logic [DATA_W-1:0] load_ext;
  logic [ADDR_W-1:0] bus_addr;

  assign busy = (state_q == RADDR) || (state_q == RDATA) ||
                (state_q == WRITE) || (state_q == BRESP);

  // All bus/handshake outputs decode straight from registered state, so a
  // timeout or reset drops them in the same cycle the FSM leaves the state.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign arvalid   = (state_q == RADDR);
  assign rready    = (state_q == RDATA);
  assign awvalid   = (state_q == WRITE) && !aw_done_q;
  assign wvalid    = (state_q == WRITE) && !w_done_q;
  assign bready    = (state_q == BRESP);

  assign bus_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign araddr    = bus_addr;
  assign awaddr    = bus_addr;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .offset_i     (addr_q[OFF_W-1:0]),
    .size_i       (size_q),
    .sext_i       (sext_q),
    .store_data_i (wdata_q),
    .load_data_i  (rdata),
    .store_data_o (wdata),
    .strb_o       (wstrb),
    .load_data_o  (load_ext)
  );

  // Watchdog: counts busy cycles; fires in the TIMEOUT-th busy cycle.
  generate
    if (TIMEOUT > 0) begin : g_watchdog
      localparam int WD_W = $clog2(TIMEOUT + 1);
      logic [WD_W-1:0] wd_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wd_q <= '0;
        end else if (!busy) begin
          wd_q <= '0;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end

      assign timeout = busy && (wd_q == WD_W'(TIMEOUT - 1));
    end else begin : g_no_watchdog
      assign timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (is_misaligned(req_addr[2:0], req_size, (DATA_W == 64))) begin
            state_d     = DONE;
            rsp_err_d   = ERR_MISALIGN;
            rsp_rdata_d = '0;
          end else if (req_we) begin
            state_d = WRITE;
          end else begin
            state_d = RADDR;
          end
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
          rsp_rdata_d = load_ext;
          rsp_err_d   = resp_is_err(rresp) ? ERR_BUS : ERR_OK;
          state_d     = DONE;
        end
      end
      WRITE: begin
        // A ready seen after a channel's own handshake is harmless: the
        // flag is already set and the channel's valid is low.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = BRESP;
      end
      BRESP: begin
        if (bvalid) begin
          rsp_rdata_d = '0;
          rsp_err_d   = resp_is_err(bresp) ? ERR_BUS : ERR_OK;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The watchdog wins over a handshake landing in the same cycle.
    if (timeout) begin
      state_d     = DONE;
      rsp_err_d   = ERR_TIMEOUT;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SZ_B;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (req_valid && (state_q == IDLE)) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        sext_q  <= req_sext;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule : lsu_axil
`default_nettype wire
